// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: widths, func codes, ROB entry layout.
package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_IDX_W = 3;
  localparam int REG_W     = 4;
  localparam int DATA_W    = 16;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;
  localparam logic [3:0] FUNC_LD  = 4'b0100;
  localparam logic [3:0] FUNC_ST  = 4'b0101;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [REG_W-1:0]  rd;
    logic [3:0]        func;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire
// of one entry per cycle. Occupancy is tracked by an explicit counter so that
// head==tail is unambiguous (full vs empty).
module rob_commit #(
  parameter int DEPTH  = tomasulo_pkg::ROB_DEPTH,
  parameter int IDX_W  = tomasulo_pkg::ROB_IDX_W,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int REG_W  = tomasulo_pkg::REG_W
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic [3:0]        alloc_func,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_rob_ind,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_drop,
  output logic              commit_valid,
  output logic [IDX_W-1:0]  commit_rob_ind,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic              commit_is_store,
  output logic [IDX_W:0]    count,
  output logic              empty
);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [REG_W-1:0]  rd;
    logic [3:0]        func;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  entry_t              ent_q [DEPTH];
  entry_t              ent_d [DEPTH];
  logic [IDX_W-1:0]    head_q, head_d;
  logic [IDX_W-1:0]    tail_q, tail_d;
  logic [IDX_W:0]      count_q, count_d;
  logic                commit_valid_q, commit_valid_d;
  logic [IDX_W-1:0]    commit_rob_ind_q, commit_rob_ind_d;
  logic [REG_W-1:0]    commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]   commit_data_q, commit_data_d;
  logic                commit_is_store_q, commit_is_store_d;
  logic                wb_drop_q, wb_drop_d;

  logic do_alloc, do_commit, wb_hit;

  // No credit from a same-cycle retire: readiness looks only at registered occupancy.
  assign alloc_ready = (count_q < DEPTH_C);
  assign alloc_idx   = tail_q;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_commit   = ent_q[head_q].valid && ent_q[head_q].done;
  assign wb_hit      = wb_valid && ent_q[wb_rob_ind].valid && !ent_q[wb_rob_ind].done;

  // Next-state: flush wins; otherwise retire head, absorb writeback, allocate tail.
  // The three entry updates never target the same slot: retire needs done=1,
  // writeback needs done=0, and alloc needs an invalid slot.
  always_comb begin
    ent_d             = ent_q;
    head_d            = head_q;
    tail_d            = tail_q;
    count_d           = count_q;
    commit_valid_d    = 1'b0;
    commit_rob_ind_d  = commit_rob_ind_q;
    commit_rd_d       = commit_rd_q;
    commit_data_d     = commit_data_q;
    commit_is_store_d = commit_is_store_q;
    wb_drop_d         = 1'b0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      head_d            = '0;
      tail_d            = '0;
      count_d           = '0;
      commit_rob_ind_d  = '0;
      commit_rd_d       = '0;
      commit_data_d     = '0;
      commit_is_store_d = 1'b0;
    end else begin
      if (do_commit) begin
        commit_valid_d       = 1'b1;
        commit_rob_ind_d     = head_q;
        commit_rd_d          = ent_q[head_q].rd;
        commit_data_d        = ent_q[head_q].data;
        commit_is_store_d    = (ent_q[head_q].func == tomasulo_pkg::FUNC_ST);
        ent_d[head_q].valid  = 1'b0;
        ent_d[head_q].done   = 1'b0;
        head_d               = head_q + 1'b1;
      end
      if (wb_hit) begin
        ent_d[wb_rob_ind].done = 1'b1;
        ent_d[wb_rob_ind].data = wb_data;
      end else begin
        wb_drop_d = wb_valid;
      end
      if (do_alloc) begin
        ent_d[tail_q] = '{valid: 1'b1, done: 1'b0, rd: alloc_rd,
                          func: alloc_func, data: '0};
        tail_d        = tail_q + 1'b1;
      end
      count_d = count_q + {{IDX_W{1'b0}}, do_alloc} - {{IDX_W{1'b0}}, do_commit};
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      commit_valid_q    <= 1'b0;
      commit_rob_ind_q  <= '0;
      commit_rd_q       <= '0;
      commit_data_q     <= '0;
      commit_is_store_q <= 1'b0;
      wb_drop_q         <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      commit_valid_q    <= commit_valid_d;
      commit_rob_ind_q  <= commit_rob_ind_d;
      commit_rd_q       <= commit_rd_d;
      commit_data_q     <= commit_data_d;
      commit_is_store_q <= commit_is_store_d;
      wb_drop_q         <= wb_drop_d;
    end
  end

  assign commit_valid    = commit_valid_q;
  assign commit_rob_ind  = commit_rob_ind_q;
  assign commit_rd       = commit_rd_q;
  assign commit_data     = commit_data_q;
  assign commit_is_store = commit_is_store_q;
  assign wb_drop         = wb_drop_q;
  assign count           = count_q;
  assign empty           = (count_q == '0);

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios with literal expectations, then
// random traffic, all continuously compared against a queue-based ROB model.
module tb_rob_commit;
  import tomasulo_pkg::*;

  logic        clk1, rst_n, flush;
  logic        alloc_valid, alloc_ready;
  logic [3:0]  alloc_rd, alloc_func;
  logic [2:0]  alloc_idx;
  logic        wb_valid, wb_drop;
  logic [2:0]  wb_rob_ind;
  logic [15:0] wb_data;
  logic        commit_valid, commit_is_store;
  logic [2:0]  commit_rob_ind;
  logic [3:0]  commit_rd;
  logic [15:0] commit_data;
  logic [3:0]  count;
  logic        empty;

  rob_commit dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_func(alloc_func),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_rob_ind(wb_rob_ind), .wb_data(wb_data), .wb_drop(wb_drop),
    .commit_valid(commit_valid), .commit_rob_ind(commit_rob_ind), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_is_store(commit_is_store),
    .count(count), .empty(empty)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: program-order queue of pending rob indices plus per-index payload.
  int          m_q[$];
  bit          m_done[8];
  logic [3:0]  m_rd[8], m_fn[8];
  logic [15:0] m_data[8];
  int          m_tail;
  bit          e_cv, e_drop, e_st;
  int          e_idx;
  logic [3:0]  e_rd;
  logic [15:0] e_data;

  function automatic bit pending(input int idx);
    foreach (m_q[k]) if (m_q[k] == idx) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n || flush) begin
      m_q.delete();
      m_tail = 0;
      e_cv   = 0;
      e_drop = 0;
    end else begin
      bit c, a, h;
      int w;
      c = (m_q.size() > 0) && m_done[m_q[0]];
      a = alloc_valid && (m_q.size() < 8);
      w = int'(wb_rob_ind);
      h = wb_valid && pending(w) && !m_done[w];
      e_cv   = c;
      e_drop = wb_valid && !h;
      if (c) begin
        e_idx  = m_q[0];
        e_rd   = m_rd[e_idx];
        e_data = m_data[e_idx];
        e_st   = (m_fn[e_idx] == 4'b0101);
        void'(m_q.pop_front());
      end
      if (h) begin
        m_done[w] = 1'b1;
        m_data[w] = wb_data;
      end
      if (a) begin
        m_q.push_back(m_tail);
        m_done[m_tail] = 1'b0;
        m_rd[m_tail]   = alloc_rd;
        m_fn[m_tail]   = alloc_func;
        m_data[m_tail] = 16'h0;
        m_tail = (m_tail + 1) % 8;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk1) begin
    if (chk_en) begin
      chk("alloc_ready", 32'(alloc_ready), 32'(m_q.size() < 8));
      chk("alloc_idx", 32'(alloc_idx), 32'(m_tail));
      chk("count", 32'(count), 32'(m_q.size()));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("commit_valid", 32'(commit_valid), 32'(e_cv));
      chk("wb_drop", 32'(wb_drop), 32'(e_drop));
      if (e_cv) begin
        chk("commit_rob_ind", 32'(commit_rob_ind), 32'(e_idx));
        chk("commit_rd", 32'(commit_rd), 32'(e_rd));
        chk("commit_data", 32'(commit_data), 32'(e_data));
        chk("commit_is_store", 32'(commit_is_store), 32'(e_st));
      end
    end
  end

  task automatic cyc(input logic av, input logic [3:0] rd, input logic [3:0] fn,
                     input logic wv, input logic [2:0] wi, input logic [15:0] wd,
                     input logic fl);
    alloc_valid = av; alloc_rd = rd; alloc_func = fn;
    wb_valid = wv; wb_rob_ind = wi; wb_data = wd; flush = fl;
    @(negedge clk1);
  endtask

  task automatic idle();
    cyc(0, 4'd0, 4'd0, 0, 3'd0, 16'h0, 0);
  endtask

  task automatic do_flush();
    cyc(0, 4'd0, 4'd0, 0, 3'd0, 16'h0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_valid = 0; alloc_rd = 0; alloc_func = 0;
    wb_valid = 0; wb_rob_ind = 0; wb_data = 0; flush = 0;
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    chk_en = 1;

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_idx", 32'(alloc_idx), 0);
    chk("rst_cv", 32'(commit_valid), 0);
    chk("rst_data", 32'(commit_data), 0);
    chk("rst_rd", 32'(commit_rd), 0);

    // 1: three allocs, wb idx0, commit one edge later
    cyc(1, 4'd1, FUNC_ADD, 0, 3'd0, 16'h0, 0);
    cyc(1, 4'd2, FUNC_SUB, 0, 3'd0, 16'h0, 0);
    cyc(1, 4'd3, FUNC_MUL, 0, 3'd0, 16'h0, 0);
    chk("t1_count3", 32'(count), 3);
    cyc(0, 4'd0, 4'd0, 1, 3'd0, 16'h0011, 0);
    chk("t1_no_bypass", 32'(commit_valid), 0);
    idle();
    chk("t1_cv", 32'(commit_valid), 1);
    chk("t1_rd", 32'(commit_rd), 1);
    chk("t1_data", 32'(commit_data), 32'h0011);
    chk("t1_count2", 32'(count), 2);

    // 2: out-of-order writebacks retire in order
    do_flush();
    repeat (3) cyc(1, 4'd4, FUNC_ADD, 0, 3'd0, 16'h0, 0);
    cyc(0, 4'd0, 4'd0, 1, 3'd2, 16'h0030, 0);
    cyc(0, 4'd0, 4'd0, 1, 3'd1, 16'h0020, 0);
    chk("t2_wait", 32'(commit_valid), 0);
    cyc(0, 4'd0, 4'd0, 1, 3'd0, 16'h0010, 0);
    chk("t2_wait2", 32'(commit_valid), 0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("t2_cv", 32'(commit_valid), 1);
      chk("t2_idx", 32'(commit_rob_ind), 32'(k));
      chk("t2_data", 32'(commit_data), 32'(16'h0010 * (k + 1)));
    end

    // 3: fill, overflow attempt, retire while full, tail wrap
    do_flush();
    for (int k = 0; k < 8; k++) cyc(1, 4'(k), FUNC_ADD, 0, 3'd0, 16'h0, 0);
    chk("t3_full_ready", 32'(alloc_ready), 0);
    chk("t3_full_count", 32'(count), 8);
    cyc(1, 4'd15, FUNC_ADD, 0, 3'd0, 16'h0, 0);
    chk("t3_ovf_count", 32'(count), 8);
    chk("t3_wrap_idx", 32'(alloc_idx), 0);
    cyc(1, 4'd15, FUNC_ADD, 1, 3'd0, 16'h0055, 0);
    cyc(1, 4'd9, FUNC_ADD, 0, 3'd0, 16'h0, 0);
    chk("t3_commit_full", 32'(commit_valid), 1);
    chk("t3_count7", 32'(count), 7);
    cyc(1, 4'd9, FUNC_ADD, 0, 3'd0, 16'h0, 0);
    chk("t3_readmit", 32'(count), 8);
    chk("t3_idx1", 32'(alloc_idx), 1);
    cyc(0, 4'd0, 4'd0, 1, 3'd1, 16'h0066, 0);
    idle();
    chk("t3_count7b", 32'(count), 7);
    cyc(0, 4'd0, 4'd0, 1, 3'd2, 16'h0077, 0);
    cyc(1, 4'd10, FUNC_ADD, 0, 3'd0, 16'h0, 0);
    chk("t3_same_edge_cv", 32'(commit_valid), 1);
    chk("t3_same_edge_cnt", 32'(count), 7);

    // 4: writeback to invalid entry and duplicate writeback
    do_flush();
    cyc(1, 4'd1, FUNC_ADD, 0, 3'd0, 16'h0, 0);
    cyc(0, 4'd0, 4'd0, 1, 3'd5, 16'h0099, 0);
    chk("t4_drop_inv", 32'(wb_drop), 1);
    cyc(0, 4'd0, 4'd0, 1, 3'd0, 16'h00A1, 0);
    chk("t4_nodrop", 32'(wb_drop), 0);
    cyc(0, 4'd0, 4'd0, 1, 3'd0, 16'h00B2, 0);
    chk("t4_drop_dup", 32'(wb_drop), 1);
    chk("t4_data_kept", 32'(commit_data), 32'h00A1);

    // 5: store retire
    do_flush();
    cyc(1, 4'd7, FUNC_ST, 0, 3'd0, 16'h0, 0);
    cyc(0, 4'd0, 4'd0, 1, 3'd0, 16'h00AB, 0);
    idle();
    chk("t5_store", 32'(commit_is_store), 1);
    chk("t5_data", 32'(commit_data), 32'h00AB);
    chk("t5_rd", 32'(commit_rd), 7);

    // 6: flush with pending work and same-cycle traffic, then async reset
    do_flush();
    for (int k = 1; k <= 5; k++) cyc(1, 4'(k), FUNC_ADD, 0, 3'd0, 16'h0, 0);
    cyc(0, 4'd0, 4'd0, 1, 3'd0, 16'h0001, 0);
    cyc(1, 4'd6, FUNC_ADD, 1, 3'd1, 16'h0002, 1);
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_cv", 32'(commit_valid), 0);
    chk("t6_drop", 32'(wb_drop), 0);
    chk("t6_idx", 32'(alloc_idx), 0);
    idle();
    chk("t6_cv_after", 32'(commit_valid), 0);
    for (int k = 1; k <= 3; k++) cyc(1, 4'(k), FUNC_ADD, 0, 3'd0, 16'h0, 0);
    cyc(0, 4'd0, 4'd0, 1, 3'd0, 16'h0003, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_count", 32'(count), 0);
    chk("t6_arst_cv", 32'(commit_valid), 0);
    alloc_valid = 0; wb_valid = 0; flush = 0;
    @(negedge clk1);
    rst_n = 1'b1;
    chk("t6_arst_idx", 32'(alloc_idx), 0);
    chk("t6_arst_empty", 32'(empty), 1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] wi;
      if (m_q.size() > 0 && $urandom_range(9) < 7)
        wi = 3'(m_q[$urandom_range(m_q.size() - 1)]);
      else
        wi = 3'($urandom_range(7));
      cyc(1'($urandom_range(9) < 6), 4'($urandom), 4'($urandom_range(5)),
          1'($urandom_range(1)), wi, 16'($urandom), 1'($urandom_range(63) == 0));
    end
    idle();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
